// File: rtl/mem_strobe_ctrl_if.sv
// Bus bundle between the CPU sequencer, the strobe controller and external SRAM/IO.
// mem_ready exists only when MEM_READY_EN is defined.
interface mem_strobe_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_READY_EN
  logic              mem_ready;
`endif
  logic              nCS;
  logic              nDRD;
  logic              nDWR;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_doe;
  logic [DATA_W-1:0] rdata_out;
  logic              busy;
  logic              done;

  // Controller view.
  modport slave (
`ifdef MEM_READY_EN
    input  mem_ready,
`endif
    input  start, ir, addr_in, wdata_in, mem_rdata,
    output nCS, nDRD, nDWR, mem_addr, mem_wdata, mem_doe, rdata_out, busy, done
  );

  // Sequencer plus memory view, driving everything the controller samples.
  modport master (
`ifdef MEM_READY_EN
    output mem_ready,
`endif
    output start, ir, addr_in, wdata_in, mem_rdata,
    input  nCS, nDRD, nDWR, mem_addr, mem_wdata, mem_doe, rdata_out, busy, done
  );
endinterface

// File: rtl/mem_strobe_ctrl.sv
// Registered memory strobe controller: setup / strobe (WAIT_CYC+1 cycles) / hold per load or store.
// Optional MEM_READY_EN stretches the strobe until mem_ready is high.
//
// state  | meaning
// IDLE   | waiting for start; non-memory opcodes answer with done only
// SETUP  | nCS low, address (and write data) driven, strobes high
// STROBE | nDRD or nDWR low while the wait counter runs down
// HOLD   | strobes released, nCS low, done pulse
module mem_strobe_ctrl #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          WAIT_CYC = 1,
  parameter logic [4:0]  OP_ST    = 5'b01100,
  parameter logic [4:0]  OP_LD    = 5'b01110
) (
  input  logic           clk,
  input  logic           rst,
  mem_strobe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} stateE;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  stateE             state, stateNext;
  logic [3:0]        waitCnt, waitCntNext;
  logic              isStore, isStoreNext;
  logic [ADDR_W-1:0] addrReg, addrNext;
  logic [DATA_W-1:0] wdataReg, wdataNext;
  logic [DATA_W-1:0] rdataReg, rdataNext;
  logic              nCSReg, nDRDReg, nDWRReg, doeReg, busyReg, doneReg;
  logic              nCSNext, nDRDNext, nDWRNext, doeNext, busyNext, doneNext;
  logic              nonMemDone;
  logic              readyOk;
  logic [4:0]        opcode;
  logic              opLoad, opStore;
  logic              unusedIrBits;

  assign opcode       = bus.ir[15:11];
  assign opLoad       = (opcode == OP_LD);
  assign opStore      = (opcode == OP_ST);
  assign unusedIrBits = ^bus.ir[10:0];

`ifdef MEM_READY_EN
  assign readyOk = bus.mem_ready;
`else
  assign readyOk = 1'b1;
`endif

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    isStoreNext = isStore;
    addrNext    = addrReg;
    wdataNext   = wdataReg;
    rdataNext   = rdataReg;
    nonMemDone  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (opLoad || opStore) begin
            stateNext   = SETUP;
            isStoreNext = opStore;
            addrNext    = bus.addr_in;
            wdataNext   = bus.wdata_in;
          end else begin
            nonMemDone = 1'b1;
          end
        end
      end
      SETUP: begin
        stateNext   = STROBE;
        waitCntNext = WAIT_INIT;
      end
      STROBE: begin
        // Counter keeps running down independently of mem_ready; exit needs both.
        if (waitCnt == 4'd0) begin
          if (readyOk) begin
            stateNext = HOLD;
            if (!isStore) rdataNext = bus.mem_rdata;
          end
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      HOLD: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Outputs are the registered image of the state being entered, so no glitches.
    nCSNext  = (stateNext == IDLE);
    nDRDNext = !((stateNext == STROBE) && !isStoreNext);
    nDWRNext = !((stateNext == STROBE) && isStoreNext);
    doeNext  = (stateNext != IDLE) && isStoreNext;
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == HOLD) || nonMemDone;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      isStore  <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
      nCSReg   <= 1'b1;
      nDRDReg  <= 1'b1;
      nDWRReg  <= 1'b1;
      doeReg   <= 1'b0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitCntNext;
      isStore  <= isStoreNext;
      addrReg  <= addrNext;
      wdataReg <= wdataNext;
      rdataReg <= rdataNext;
      nCSReg   <= nCSNext;
      nDRDReg  <= nDRDNext;
      nDWRReg  <= nDWRNext;
      doeReg   <= doeNext;
      busyReg  <= busyNext;
      doneReg  <= doneNext;
    end
  end

  assign bus.nCS       = nCSReg;
  assign bus.nDRD      = nDRDReg;
  assign bus.nDWR      = nDWRReg;
  assign bus.mem_addr  = addrReg;
  assign bus.mem_wdata = wdataReg;
  assign bus.mem_doe   = doeReg;
  assign bus.rdata_out = rdataReg;
  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;

endmodule

// File: tb/tb_mem_strobe_ctrl.sv
// Directed bench for mem_strobe_ctrl: one instance with WAIT_CYC=1, one with WAIT_CYC=0.
// Cycle c counts clocks after the edge that samples start; outputs are sampled on negedges.
module tb_mem_strobe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_strobe_ctrl_if #(.DATA_W(16), .ADDR_W(16)) busW1 ();
  mem_strobe_ctrl_if #(.DATA_W(16), .ADDR_W(16)) busW0 ();

  mem_strobe_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(1)) u_dutW1 (.clk(clk), .rst(rst), .bus(busW1));
  mem_strobe_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(0)) u_dutW0 (.clk(clk), .rst(rst), .bus(busW0));

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int lowCnt, doneAt, doneCnt;
  logic flag, doeOk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    busW1.start = 0; busW1.ir = 0; busW1.addr_in = 0; busW1.wdata_in = 0; busW1.mem_rdata = 0;
    busW0.start = 0; busW0.ir = 0; busW0.addr_in = 0; busW0.wdata_in = 0; busW0.mem_rdata = 0;
`ifdef MEM_READY_EN
    busW1.mem_ready = 1; busW0.mem_ready = 1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset nCS",       {31'd0, busW1.nCS},  32'd1);
    check("reset nDRD",      {31'd0, busW1.nDRD}, 32'd1);
    check("reset nDWR",      {31'd0, busW1.nDWR}, 32'd1);
    check("reset busy",      {31'd0, busW1.busy}, 32'd0);
    check("reset done",      {31'd0, busW1.done}, 32'd0);
    check("reset doe",       {31'd0, busW1.mem_doe}, 32'd0);
    check("reset mem_addr",  {16'd0, busW1.mem_addr}, 32'd0);
    check("reset rdata_out", {16'd0, busW1.rdata_out}, 32'd0);
    rst = 0;

    // Load with WAIT_CYC=1.
    busW1.ir = 16'h7000; busW1.addr_in = 16'h0040; busW1.mem_rdata = 16'hBEEF; busW1.start = 1;
    lowCnt = 0; doneAt = 0; flag = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      busW1.start = 0;
      if (!busW1.nDRD) lowCnt++;
      if (busW1.done && doneAt == 0) doneAt = c;
      if (!busW1.nDRD && !busW1.nDWR) flag = 1;
      if (c == 1) begin
        check("load setup nCS",  {31'd0, busW1.nCS},  32'd0);
        check("load setup busy", {31'd0, busW1.busy}, 32'd1);
        check("load setup nDRD", {31'd0, busW1.nDRD}, 32'd1);
      end
    end
    check("load strobe width", lowCnt, 32'd2);
    check("load done cycle",   doneAt, 32'd4);
    check("load rdata_out",    {16'd0, busW1.rdata_out}, 32'h0000BEEF);
    check("load mem_addr",     {16'd0, busW1.mem_addr},  32'h00000040);
    check("load no overlap",   {31'd0, flag}, 32'd0);
    check("load idle busy",    {31'd0, busW1.busy}, 32'd0);

    // Non-memory opcode: done only, no bus activity.
    busW1.ir = 16'h0800; busW1.mem_rdata = 16'h0000; busW1.start = 1;
    flag = 0; doneCnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      busW1.start = 0;
      if (busW1.done) doneCnt++;
      if (!busW1.nCS || !busW1.nDRD || !busW1.nDWR || busW1.busy) flag = 1;
      if (c == 1) check("nonmem done at N+1", {31'd0, busW1.done}, 32'd1);
    end
    check("nonmem single done",  doneCnt, 32'd1);
    check("nonmem no bus",       {31'd0, flag}, 32'd0);
    check("nonmem rdata held",   {16'd0, busW1.rdata_out}, 32'h0000BEEF);

    // Store with WAIT_CYC=0, then a load started in the first IDLE cycle.
    busW0.ir = 16'h6000; busW0.addr_in = 16'h0123; busW0.wdata_in = 16'h1234; busW0.start = 1;
    lowCnt = 0; doneAt = 0; flag = 0; doeOk = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      busW0.start = (c == 4);
      if (c == 4) begin
        busW0.ir = 16'h7000; busW0.addr_in = 16'h0200; busW0.mem_rdata = 16'h5A5A;
        check("b2b first idle busy", {31'd0, busW0.busy}, 32'd0);
      end
      if (c <= 3) begin
        if (!busW0.nDWR) lowCnt++;
        if (busW0.done && doneAt == 0) doneAt = c;
        if (!busW0.nDRD) flag = 1;
        if (!busW0.mem_doe || busW0.mem_wdata !== 16'h1234) doeOk = 0;
      end
      if (c == 5) begin
        check("b2b accepted nCS",  {31'd0, busW0.nCS}, 32'd0);
        check("b2b mem_addr",      {16'd0, busW0.mem_addr}, 32'h00000200);
      end
      if (c == 7) begin
        check("b2b done",          {31'd0, busW0.done}, 32'd1);
        check("b2b rdata_out",     {16'd0, busW0.rdata_out}, 32'h00005A5A);
      end
    end
    check("store strobe width",   lowCnt, 32'd1);
    check("store done cycle",     doneAt, 32'd3);
    check("store no nDRD",        {31'd0, flag}, 32'd0);
    check("store doe and wdata",  {31'd0, doeOk}, 32'd1);

    // start re-pulsed during STROBE is ignored.
    busW1.ir = 16'h7000; busW1.addr_in = 16'h0055; busW1.mem_rdata = 16'hCAFE; busW1.start = 1;
    doneCnt = 0; flag = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      busW1.start = (c == 2);
      if (c == 2) begin
        busW1.addr_in = 16'h0AAA; busW1.ir = 16'h6000;
        check("repulse in strobe", {31'd0, busW1.nDRD}, 32'd0);
      end
      if (busW1.done) doneCnt++;
      if (!busW1.nDWR) flag = 1;
    end
    check("repulse one done",  doneCnt, 32'd1);
    check("repulse mem_addr",  {16'd0, busW1.mem_addr}, 32'h00000055);
    check("repulse rdata_out", {16'd0, busW1.rdata_out}, 32'h0000CAFE);
    check("repulse no store",  {31'd0, flag}, 32'd0);

    // Reset mid-STROBE of a store; no retry afterwards.
    busW1.ir = 16'h6000; busW1.addr_in = 16'h0077; busW1.wdata_in = 16'h9999; busW1.start = 1;
    @(negedge clk);
    busW1.start = 0;
    @(negedge clk);
    check("rst pre nDWR low", {31'd0, busW1.nDWR}, 32'd0);
    rst = 1;
    @(negedge clk);
    check("rst nDWR",      {31'd0, busW1.nDWR}, 32'd1);
    check("rst nCS",       {31'd0, busW1.nCS},  32'd1);
    check("rst busy",      {31'd0, busW1.busy}, 32'd0);
    check("rst doe",       {31'd0, busW1.mem_doe}, 32'd0);
    check("rst rdata_out", {16'd0, busW1.rdata_out}, 32'd0);
    @(negedge clk);
    rst = 0;
    flag = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (!busW1.nDWR || busW1.busy || busW1.done) flag = 1;
    end
    check("rst no retry", {31'd0, flag}, 32'd0);

`ifdef MEM_READY_EN
    // mem_ready low for the first three strobe cycles stretches the strobe.
    busW0.ir = 16'h7000; busW0.addr_in = 16'h0300; busW0.mem_rdata = 16'h1111;
    busW0.mem_ready = 0; busW0.start = 1;
    lowCnt = 0; doneAt = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      busW0.start = 0;
      if (c == 5) busW0.mem_ready = 1;
      if (!busW0.nDRD) lowCnt++;
      if (busW0.done && doneAt == 0) doneAt = c;
    end
    check("ready strobe width", lowCnt, 32'd4);
    check("ready done cycle",   doneAt, 32'd6);
    check("ready rdata_out",    {16'd0, busW0.rdata_out}, 32'h00001111);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_strobe_ctrl.md
# mem_strobe_ctrl

Parametrised memory strobe controller for the multi-cycle CPU datapath. It decodes the instruction opcode when the controller issues a start pulse, then runs a timed access sequence on the external memory bus: address setup, active-low read/write strobe for a configurable number of wait cycles, and hold. It replaces the single-beat combinational strobe decode with a registered, glitch-free FSM. It sits between the CPU control sequencer and the external SRAM/IO bus.

## Interface
- DATA_W, 16, data bus width
- ADDR_W, 16, address bus width
- WAIT_CYC, 1, extra strobe-low cycles beyond the first; legal 0..15
- OP_ST, 5'b01100, ir[15:11] opcode for store (write)
- OP_LD, 5'b01110, ir[15:11] opcode for load (read)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request from sequencer (T2 beat)
- ir  in  16  current instruction
- addr_in  in  ADDR_W  effective address
- wdata_in  in  DATA_W  store data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory ready (present only with MEM_READY_EN)
- nCS  out  1  chip select, active low
- nDRD  out  1  read strobe, active low
- nDWR  out  1  write strobe, active low
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_doe  out  1  drive-enable for write data bus
- rdata_out  out  DATA_W  captured read data
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: start=1 with ir[15:11]=OP_LD or OP_ST → latch addr_in, wdata_in, and op type; go to SETUP. start=1 with any other opcode → done=1 next cycle, no bus activity, remain IDLE.
- SETUP (1 cycle): nCS=0, mem_addr valid, strobes high; mem_doe=1 for store. Load 4-bit wait counter with WAIT_CYC.
- STROBE: nDRD=0 (load) or nDWR=0 (store); counter decrements each cycle; leave when counter==0 (and, with macro, mem_ready=1). On the leaving edge of a load, capture mem_rdata into rdata_out.
- HOLD (1 cycle): strobes high, nCS=0, mem_addr and mem_wdata held, done=1; then IDLE.
- busy=1 in SETUP, STROBE, HOLD.
- start while busy is ignored, with no queuing.
- nDRD and nDWR are never low simultaneously. Both are high outside STROBE.
- All outputs are registered, with no combinational path from ir to strobes.
- rst (any state): next edge → IDLE, nCS=nDRD=nDWR=1, mem_doe=0, busy=0, done=0, mem_addr=0, mem_wdata=0, rdata_out=0. A strobe cut short by rst is not retried.

## Timing
- start sampled at edge N. SETUP occupies cycle N+1. Strobe low for cycles N+2 through N+2+WAIT_CYC (WAIT_CYC+1 cycles). HOLD/done at N+3+WAIT_CYC. IDLE at N+4+WAIT_CYC.
- Access latency from start to done: WAIT_CYC+3 cycles. With WAIT_CYC=0, strobe is low 1 cycle.
- rdata_out is valid from the done cycle and holds until the next load completes.
- Next start is accepted in the first IDLE cycle, so back-to-back period is WAIT_CYC+4.
- Non-memory opcode: done at N+1, busy stays 0.

## Configuration
- MEM_READY_EN defined: mem_ready port exists. STROBE extends beyond WAIT_CYC+1 cycles while mem_ready=0; exit occurs on the first cycle with counter==0 and mem_ready=1. There is no timeout. rst is the only escape.
- MEM_READY_EN undefined: no mem_ready port; strobe width is fixed at WAIT_CYC+1.

## Test plan
- Reset: rst=1 for 2 cycles mid-STROBE of a store → nDWR=1, nCS=1, busy=0, rdata_out=0 on the next edge.
- Load, WAIT_CYC=1: ir=16'h7000, addr_in=16'h0040, mem_rdata=16'hBEEF → nDRD low exactly 2 cycles, done at N+4, rdata_out=16'hBEEF.
- Store, WAIT_CYC=0: ir=16'h6000, wdata_in=16'h1234 → nDWR low 1 cycle, mem_wdata=16'h1234 and mem_doe=1 from SETUP through HOLD, done at N+3.
- Non-memory opcode ir=16'h0800 with start → done at N+1, nCS/nDRD/nDWR stay 1.
- start re-pulsed during STROBE → ignored; only one done pulse is produced, and mem_addr is unchanged.
- MEM_READY_EN, WAIT_CYC=0: hold mem_ready=0 for 3 cycles → nDRD low 4 cycles, done the cycle after mem_ready rises.
